// File: rtl/hc595_rx.sv
// hc595_rx: 595-style shift/latch link receiver with per-digit segment image; HC595_RX_SYNC_EN adds a two-flop input synchronizer
module hc595_rx #(
   parameter int SEL_W = 6,
   parameter int SEG_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ds,
   input  logic                     shcp,
   input  logic                     stcp,
   input  logic                     oe,
   output logic [SEL_W-1:0]         sel,
   output logic [SEG_W-1:0]         seg,
   output logic                     frame_vld,
   output logic [SEL_W*SEG_W-1:0]   digits,
   output logic                     cnt_err,
   output logic                     sel_err
);
   localparam int FRAME_W = SEG_W + SEL_W;
   // pin order {shcp, stcp, oe, ds}; clocks and oe idle high so release makes no edge
   localparam logic [3:0] IDLE = 4'b1110;
   logic [3:0] pin, s_in;
   logic prev_shcp, prev_stcp, rise_sh, rise_st, sel_one, sel_two, sel_ok;
   logic [FRAME_W-1:0] shreg;
   logic [4:0] bcnt;
`ifdef HC595_RX_SYNC_EN
   logic [3:0] meta;
   always_ff @(posedge clk)
      if (!rst) meta <= IDLE;
      else meta <= {shcp, stcp, oe, ds};
   assign pin = meta;
`else
   assign pin = {shcp, stcp, oe, ds};
`endif
   always_ff @(posedge clk) begin
      if (!rst) begin
         s_in <= IDLE;
         prev_shcp <= 1'b1;
         prev_stcp <= 1'b1;
      end else begin
         s_in <= pin;
         prev_shcp <= s_in[3];
         prev_stcp <= s_in[2];
      end
   end
   assign rise_sh = s_in[3] & ~prev_shcp;
   assign rise_st = s_in[2] & ~prev_stcp;
   always_comb begin
      sel_one = 1'b0;
      sel_two = 1'b0;
      for (int i = 0; i < SEL_W; i++)
         if (!shreg[i]) begin
            sel_two = sel_two | sel_one;
            sel_one = 1'b1;
         end
   end
   assign sel_ok = sel_one & ~sel_two;
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg <= '0;
         bcnt <= '0;
         sel <= '1;
         seg <= '0;
         digits <= '0;
         frame_vld <= 1'b0;
         cnt_err <= 1'b0;
         sel_err <= 1'b0;
      end else begin
         frame_vld <= rise_st;
         cnt_err <= rise_st && bcnt != 5'(FRAME_W);
         sel_err <= rise_st && !sel_ok;
         if (rise_sh) shreg <= {shreg[FRAME_W-2:0], s_in[0]};
         // latch sees the pre-shift register, like the real part
         if (rise_st) begin
            {seg, sel} <= shreg;
            bcnt <= {4'b0, rise_sh};
            for (int i = 0; i < SEL_W; i++)
               if (!s_in[1] && sel_ok && !shreg[i]) digits[i*SEG_W +: SEG_W] <= shreg[FRAME_W-1:SEL_W];
         end else if (rise_sh && bcnt != 5'd31) bcnt <= bcnt + 5'd1;
      end
   end
endmodule

// File: doc/hc595_rx.md
# hc595_rx

Serial-to-parallel receiver for the two-wire-clocked shift/latch display link (ds, shcp, stcp, oe) driven by the segment chip driver. It oversamples the link on the system clock, rebuilds each latched frame into a select/segment pair, and keeps a per-digit segment image for the whole display. It is used as the display-side model in system benches and as an on-chip loopback monitor. Frames with a wrong bit count or a bad select pattern are flagged.

## Interface
- SEL_W, 6, digit-select bits per frame (one per digit)
- SEG_W, 8, segment bits per frame; frame length FRAME_W = SEG_W + SEL_W
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- ds  in  1  serial data
- shcp  in  1  shift clock; a rising edge shifts in ds
- stcp  in  1  storage clock; a rising edge latches the frame
- oe  in  1  output enable, active-low
- sel  out  SEL_W  latched select, active-low one-hot (bit i low = digit i)
- seg  out  SEG_W  latched segment pattern
- frame_vld  out  1  one-cycle pulse per latched frame
- digits  out  SEL_W*SEG_W  segment image; digit i at [i*SEG_W +: SEG_W]
- cnt_err  out  1  one-cycle pulse: shcp-edge count since last latch != FRAME_W
- sel_err  out  1  one-cycle pulse: latched sel not exactly one bit low

## Operation
- Input stage: ds, shcp, stcp, oe each registered (depth per Configuration) into s_ds, s_shcp, s_stcp, s_oe; prev_shcp, prev_stcp hold the previous s_ values.
- rise_sh = s_shcp & ~prev_shcp; rise_st = s_stcp & ~prev_stcp.
- Shift: on rise_sh, shreg <= {shreg[FRAME_W-2:0], s_ds}. First bit shifted lands in MSB. Frame order: seg MSB first, then sel MSB first; after FRAME_W shifts shreg = {seg, sel}.
- Latch: on rise_st, {seg, sel} <= shreg (pre-shift value when rise_sh occurs in same cycle, as a real 595 latch); frame_vld <= 1.
- Bit counter bcnt (5 bits, saturates at 31): +1 on rise_sh; on rise_st cleared to 0, or to 1 if rise_sh in same cycle. On rise_st, cnt_err pulses if bcnt (pre-update) != FRAME_W.
- Select check: on rise_st, sel_err pulses unless shreg[SEL_W-1:0] has exactly one zero bit.
- Digit image: on rise_st, if s_oe == 0 and select check passes, digit i (the zero bit) <= shreg[FRAME_W-1:SEL_W]. Otherwise image unchanged. sel/seg latch regardless of oe and errors.
- No state machine beyond the counter; link is edge-driven, no backpressure.

## Timing
- Reset (rst low at a clk edge): sel = all ones, seg = 0, digits = 0, frame_vld = cnt_err = sel_err = 0, shreg = 0, bcnt = 0; shcp/stcp/oe pipeline and prev flops = 1, ds pipeline = 0 (idle-high clocks produce no edge after release).
- Reset mid-frame discards partial shreg and bcnt; first stcp after release reports cnt_err unless a full frame was shifted.
- Pin-to-effect latency: L+1 clk edges from the edge sampling the pin change to shreg/sel/frame_vld update, where L = input-stage depth.
- frame_vld, cnt_err, sel_err, digits, sel, seg all update on the same edge.
- shcp/stcp high and low phases must each last >= 1 clk (>= 2 with sync off is not required); shorter pulses are undefined.
- More than FRAME_W shifts before latch: oldest bits fall off MSB, last FRAME_W bits latch, cnt_err pulses.

## Configuration
- HC595_RX_SYNC_EN defined: L = 2 (two-flop synchronizer on all four inputs); link may be asynchronous to clk.
- Undefined: L = 1 (single register stage); inputs must be clk-synchronous, as in the on-chip loopback.

## Test plan
- After reset, shift seg=8'hC0, sel=6'b111110 (14 shcp pulses), pulse stcp, oe=0 -> one frame_vld, seg=C0, sel=3E, digits[7:0]=C0, no errors.
- Six frames, digits 0..5 with seg 8'h01..8'h06 -> digits = 48'h060504030201.
- 13 shifts then stcp -> cnt_err pulse, frame still latched; next correct frame -> no cnt_err.
- Frame with sel=6'b111100 -> sel_err pulse, digits unchanged; same valid frame with oe=1 -> sel/seg latch, digits unchanged.
- shcp and stcp rise same sample after 14 shifts -> latched value is pre-shift frame, bcnt=1.
- rst low after 7 shifts, then 14-bit frame and stcp -> frame latched correctly, no cnt_err; latency L+1 checked with and without HC595_RX_SYNC_EN.
